// File: rtl/keyexpand.sv
// keyexpand -- iterative AES-128 key schedule generator.
//
// Loads a 128-bit cipher key on an accepted start and emits round keys
// 0..10, one per clock. Round key 10 stays on rk_out until the next
// accepted start or reset. Byte 0 of every vector is bits [127:120].
//
// Ports:
//   clk       sole clock, rising edge
//   rst       synchronous active-high reset (priority over start)
//   start     load key_in and begin expansion; ignored while busy
//   key_in    cipher key, sampled on the accepting edge only
//   busy      high while round keys 1..10 are still to be produced
//   rk_valid  rk_out/rk_index carry a new round key this cycle
//   rk_index  round number of rk_out, 0..10
//   rk_out    current round key, held when not updating
//   done      one-cycle pulse together with rk_index == 10
//
// Optional feature (macro KEYEXPAND_STORE_EN):
//   rd_idx    read address into an 11 x 128 round-key store
//   rd_key    registered read data, 1-cycle latency; 0 for rd_idx > 10
//
// State table:
//   IDLE | waiting for start; outputs hold the last round key
//   RUN  | producing round keys 1..10, one per cycle

module keyexpand (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  output logic [3:0]   rk_index,
  output logic [127:0] rk_out,
  output logic         done
`ifdef KEYEXPAND_STORE_EN
  ,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
`endif
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t       state, state_nxt;
  logic [7:0]   rcon;
  logic         load, step, last;
  logic [31:0]  rot, sub, t;
  logic [31:0]  w0n, w1n, w2n, w3n;

  // One round of the schedule; four parallel S-box lookups on RotWord(w3)
  assign rot = {rk_out[23:0], rk_out[31:24]};
  assign sub = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
  assign t   = sub ^ {rcon, 24'h000000};
  assign w0n = rk_out[127:96] ^ t;
  assign w1n = rk_out[95:64]  ^ w0n;
  assign w2n = rk_out[63:32]  ^ w1n;
  assign w3n = rk_out[31:0]   ^ w2n;

  assign load = (state == IDLE) && start;
  assign step = (state == RUN);
  // The step that produces round 10 is the one leaving rk_index == 9
  assign last = step && (rk_index == 4'd9);
  assign busy = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (last)  state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rk_out   <= '0;
      rk_index <= '0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
      rcon     <= 8'h01;
    end else if (load) begin
      rk_out   <= key_in;
      rk_index <= '0;
      rk_valid <= 1'b1;
      done     <= 1'b0;
      rcon     <= 8'h01;
    end else if (step) begin
      rk_out   <= {w0n, w1n, w2n, w3n};
      rk_index <= rk_index + 4'd1;
      rk_valid <= 1'b1;
      done     <= last;
      // xtime in GF(2^8): next rcon
      rcon     <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
    end else begin
      rk_valid <= 1'b0;
      done     <= 1'b0;
    end
  end

`ifdef KEYEXPAND_STORE_EN
  logic [127:0] store [0:10];

  // Read and write share an edge, so a same-address read returns old data
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 11; i++) store[i] <= '0;
      rd_key <= '0;
    end else begin
      if (rk_valid) store[rk_index] <= rk_out;
      rd_key <= (rd_idx <= 4'd10) ? store[rd_idx] : '0;
    end
  end
`endif

endmodule

// File: tb/tb_keyexpand.sv
module tb_keyexpand;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic [3:0]   rk_index;
  logic [127:0] rk_out;
  logic         done;
`ifdef KEYEXPAND_STORE_EN
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_ref [256];
  logic [127:0] exp_rk [11];
  logic [127:0] seen_r1;

  always #5 clk = ~clk;

  keyexpand dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_index (rk_index),
    .rk_out   (rk_out),
    .done     (done)
`ifdef KEYEXPAND_STORE_EN
    ,
    .rd_idx   (rd_idx),
    .rd_key   (rd_key)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
    return (v << s) | (v >> (8 - s));
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map
  task automatic build_sbox();
    for (int b = 0; b < 256; b++) begin
      logic [7:0] inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
      sbox_ref[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Textbook word-array expansion into 44 words, grouped into 11 round keys
  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_ref[tmp[31:24]], sbox_ref[tmp[23:16]], sbox_ref[tmp[15:8]], sbox_ref[tmp[7:0]]};
        tmp ^= {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_rk"},    rk_out, 128'h0);
    chk({tag, "_idx"},   128'(rk_index), 128'h0);
    chk({tag, "_valid"}, 128'(rk_valid), 128'h0);
    chk({tag, "_busy"},  128'(busy), 128'h0);
    chk({tag, "_done"},  128'(done), 128'h0);
  endtask

  // Accept a key, then follow rounds 1..10; optionally pulse start at E0+3
  // and E0+10 (both must be ignored), or reset at edge E0+abort_at.
  task automatic run_key(input logic [127:0] key, input bit disturb, input int abort_at);
    expand(key);
    start = 1'b1; key_in = key;
    tick();
    start = 1'b0; key_in = rand128();
    chk("e0_rk", rk_out, exp_rk[0]);
    chk("e0_idx", 128'(rk_index), 128'h0);
    chk("e0_valid", 128'(rk_valid), 128'h1);
    chk("e0_busy", 128'(busy), 128'h1);
    chk("e0_done", 128'(done), 128'h0);
    for (int n = 1; n <= 10; n++) begin
      if (n == abort_at) begin
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        chk_zero("abort");
        return;
      end
      if (disturb && (n == 3 || n == 10)) start = 1'b1;
      key_in = rand128();
      tick();
      start = 1'b0;
      if (n == 1) seen_r1 = rk_out;
      chk($sformatf("r%0d_rk", n), rk_out, exp_rk[n]);
      chk($sformatf("r%0d_idx", n), 128'(rk_index), 128'(n));
      chk($sformatf("r%0d_valid", n), 128'(rk_valid), 128'h1);
      chk($sformatf("r%0d_busy", n), 128'(busy), 128'(n < 10));
      chk($sformatf("r%0d_done", n), 128'(done), 128'(n == 10));
    end
  endtask

  task automatic idle_tick();
    tick();
    chk("idle_valid", 128'(rk_valid), 128'h0);
    chk("idle_done", 128'(done), 128'h0);
    chk("idle_busy", 128'(busy), 128'h0);
    chk("idle_idx", 128'(rk_index), 128'd10);
    chk("idle_rk", rk_out, exp_rk[10]);
  endtask

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  initial begin
    rst = 1'b1; start = 1'b0; key_in = '0;
`ifdef KEYEXPAND_STORE_EN
    rd_idx = 4'd0;
`endif
    build_sbox();
    tick(); tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();
    chk_zero("post_reset");

    run_key(FIPS_KEY, 1'b0, 0);
    chk("fips_r1", seen_r1, FIPS_R1);
    chk("fips_r10", rk_out, FIPS_R10);
    idle_tick();

    run_key(128'h0, 1'b0, 0);
    chk("zero_r1", seen_r1, ZERO_R1);
    chk("zero_r10", rk_out, ZERO_R10);
    idle_tick();

    // Ignored starts mid-run, then an immediate re-accept at E0+11
    run_key(rand128(), 1'b1, 0);
    run_key(rand128(), 1'b0, 0);
    idle_tick();

    // Reset mid-run aborts; no done afterwards; then a clean FIPS run
    run_key(rand128(), 1'b0, 5);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_zero("after_abort");
    end
    run_key(FIPS_KEY, 1'b0, 0);
    chk("fips2_r1", seen_r1, FIPS_R1);
    chk("fips2_r10", rk_out, FIPS_R10);
    idle_tick();

`ifdef KEYEXPAND_STORE_EN
    rd_idx = 4'd10; tick();
    chk("store_rd10", rd_key, FIPS_R10);
    rd_idx = 4'd1; tick();
    chk("store_rd1", rd_key, FIPS_R1);
    rd_idx = 4'd0; tick();
    chk("store_rd0", rd_key, FIPS_KEY);
    rd_idx = 4'd11; tick();
    chk("store_rd11", rd_key, 128'h0);
    rd_idx = 4'd0;
`endif

    // Reset and start on the same edge: reset wins
    rst = 1'b1; start = 1'b1; key_in = rand128();
    tick();
    rst = 1'b0; start = 1'b0;
    chk_zero("rst_start");
    tick();
    chk_zero("rst_start_after");

    for (int k = 0; k < 4; k++) begin
      run_key(rand128(), 1'($urandom_range(0, 1)), 0);
      idle_tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
